// File: rtl/voice_allocator.sv
// voice_allocator: four-voice note scheduler between the MIDI event source
// and the waveform_generator note slots. Each event is handled in three
// cycles: latch (IDLE), decide (MATCH), commit (WRITE).
module voice_allocator #(
    parameter int NUM_VOICES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ev_valid,
    output logic        ev_ready,
    input  logic        ev_on,
    input  logic [6:0]  ev_note,
    input  logic [7:0]  ev_vel,
    input  logic        all_off,
    output logic [15:0] note_vol_0,
    output logic [15:0] note_vol_1,
    output logic [15:0] note_vol_2,
    output logic [15:0] note_vol_3,
    output logic [3:0]  voice_active,
    output logic        steal
);

    typedef enum logic [1:0] {
        IDLE,
        MATCH,
        WRITE
    } state_t;

    state_t      state;

    // Per-voice storage; rank 0 = most recently started, rank 3 = oldest
    logic [6:0]  note_r [NUM_VOICES];
    logic [7:0]  vol_r  [NUM_VOICES];
    logic [1:0]  rank_r [NUM_VOICES];

    // Event latched on acceptance
    logic        ev_on_q;
    logic [6:0]  ev_note_q;
    logic [7:0]  ev_vel_q;

    // Registered decision
    logic [1:0]  sel_q;
    logic        write_q;
    logic        steal_q;

    // Search results over the current voice registers
    logic        match_hit;
    logic [1:0]  match_idx;
    logic        free_hit;
    logic [1:0]  free_idx;
    logic [1:0]  oldest_idx;

    assign ev_ready = (state == IDLE) && !all_off;

    assign note_vol_0 = {1'b0, note_r[0], vol_r[0]};
    assign note_vol_1 = {1'b0, note_r[1], vol_r[1]};
    assign note_vol_2 = {1'b0, note_r[2], vol_r[2]};
    assign note_vol_3 = {1'b0, note_r[3], vol_r[3]};

    // A voice is sounding whenever its volume is non-zero
    always_comb begin
        voice_active = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            voice_active[i] = (vol_r[i] != '0);
        end
    end

    // Lowest-index matching voice, lowest-index free voice, and the oldest voice
    always_comb begin
        match_hit  = 1'b0;
        match_idx  = '0;
        free_hit   = 1'b0;
        free_idx   = '0;
        oldest_idx = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (!match_hit && note_r[i] == ev_note_q && vol_r[i] != '0) begin
                match_hit = 1'b1;
                match_idx = 2'(i);
            end
            if (!free_hit && vol_r[i] == '0) begin
                free_hit = 1'b1;
                free_idx = 2'(i);
            end
            if (rank_r[i] == 2'd3) begin
                oldest_idx = 2'(i);
            end
        end
    end

    // Event FSM: latch, decide, then commit voice registers and ranks
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ev_on_q   <= 1'b0;
            ev_note_q <= '0;
            ev_vel_q  <= '0;
            sel_q     <= '0;
            write_q   <= 1'b0;
            steal_q   <= 1'b0;
            steal     <= 1'b0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                note_r[i] <= '0;
                vol_r[i]  <= '0;
                rank_r[i] <= 2'(i);
            end
        end else begin
            steal <= 1'b0;
            case (state)
                IDLE: begin
                    if (all_off) begin
                        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                            vol_r[i] <= '0;
                        end
                    end else if (ev_valid) begin
                        // note-on with zero velocity is folded into note-off here
                        ev_on_q   <= ev_on && (ev_vel != '0);
                        ev_note_q <= ev_note;
                        ev_vel_q  <= ev_vel;
                        state     <= MATCH;
                    end
                end
                MATCH: begin
                    if (ev_on_q) begin
                        write_q <= 1'b1;
                        if (match_hit) begin
                            sel_q   <= match_idx;
                            steal_q <= 1'b0;
                        end else if (free_hit) begin
                            sel_q   <= free_idx;
                            steal_q <= 1'b0;
                        end else begin
                            sel_q   <= oldest_idx;
                            steal_q <= 1'b1;
                        end
                    end else begin
                        write_q <= match_hit;
                        sel_q   <= match_idx;
                        steal_q <= 1'b0;
                    end
                    state <= WRITE;
                end
                WRITE: begin
                    if (write_q) begin
                        if (ev_on_q) begin
                            note_r[sel_q] <= ev_note_q;
                            vol_r[sel_q]  <= ev_vel_q;
                            for (int unsigned u = 0; u < NUM_VOICES; u++) begin
                                if (rank_r[u] < rank_r[sel_q]) begin
                                    rank_r[u] <= rank_r[u] + 2'd1;
                                end
                            end
                            rank_r[sel_q] <= '0;
                        end else begin
                            vol_r[sel_q] <= '0;
                        end
                    end
                    steal <= steal_q;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed vectors for voice_allocator with hand-computed
// expected note_vol words, voice_active masks and steal pulses.
module tb_voice_allocator;

    logic        clk;
    logic        reset;
    logic        ev_valid;
    logic        ev_ready;
    logic        ev_on;
    logic [6:0]  ev_note;
    logic [7:0]  ev_vel;
    logic        all_off;
    logic [15:0] note_vol_0;
    logic [15:0] note_vol_1;
    logic [15:0] note_vol_2;
    logic [15:0] note_vol_3;
    logic [3:0]  voice_active;
    logic        steal;

    int n_checks = 0;
    int n_fail   = 0;

    voice_allocator #(.NUM_VOICES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_on        (ev_on),
        .ev_note      (ev_note),
        .ev_vel       (ev_vel),
        .all_off      (all_off),
        .note_vol_0   (note_vol_0),
        .note_vol_1   (note_vol_1),
        .note_vol_2   (note_vol_2),
        .note_vol_3   (note_vol_3),
        .voice_active (voice_active),
        .steal        (steal)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_vols(input string tag, input logic [15:0] v0, input logic [15:0] v1,
                              input logic [15:0] v2, input logic [15:0] v3);
        check({tag, ".v0"}, 32'(note_vol_0), 32'(v0));
        check({tag, ".v1"}, 32'(note_vol_1), 32'(v1));
        check({tag, ".v2"}, 32'(note_vol_2), 32'(v2));
        check({tag, ".v3"}, 32'(note_vol_3), 32'(v3));
    endtask

    // Present one event, then return #1 after the commit edge (E2)
    task automatic send(input logic on, input logic [6:0] note, input logic [7:0] vel);
        int waited = 0;
        @(negedge clk);
        while (!ev_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", 32'(ev_ready), 32'd1);
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = note;
        ev_vel   = vel;
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
        ev_on    = 1'b0;
        ev_note  = '0;
        ev_vel   = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        ev_valid = 1'b0;
        ev_on    = 1'b0;
        ev_note  = '0;
        ev_vel   = '0;
        all_off  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_vols("reset", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check("reset.active", 32'(voice_active), 32'h0);
        check("reset.steal", 32'(steal), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset.ready", 32'(ev_ready), 32'd1);

        // Fill all four voices
        send(1'b1, 7'd60, 8'h40);
        check_vols("fill60", 16'h3C40, 16'h0000, 16'h0000, 16'h0000);
        send(1'b1, 7'd64, 8'h40);
        check_vols("fill64", 16'h3C40, 16'h4040, 16'h0000, 16'h0000);
        send(1'b1, 7'd67, 8'h40);
        check_vols("fill67", 16'h3C40, 16'h4040, 16'h4340, 16'h0000);
        send(1'b1, 7'd72, 8'h40);
        check_vols("fill72", 16'h3C40, 16'h4040, 16'h4340, 16'h4840);
        check("fill.active", 32'(voice_active), 32'hF);
        check("fill.steal", 32'(steal), 32'd0);

        // Fifth note steals the oldest (voice 0)
        send(1'b1, 7'd76, 8'h50);
        check_vols("steal76", 16'h4C50, 16'h4040, 16'h4340, 16'h4840);
        check("steal76.pulse", 32'(steal), 32'd1);
        @(posedge clk);
        #1;
        check("steal76.pulse_end", 32'(steal), 32'd0);

        // Note-off frees voice 1, which is then reused
        send(1'b0, 7'd64, 8'h00);
        check_vols("off64", 16'h4C50, 16'h4000, 16'h4340, 16'h4840);
        check("off64.active", 32'(voice_active), 32'hD);
        send(1'b1, 7'd55, 8'h30);
        check_vols("on55", 16'h4C50, 16'h3730, 16'h4340, 16'h4840);
        check("on55.steal", 32'(steal), 32'd0);

        // Note-off without a match changes nothing
        send(1'b0, 7'd99, 8'h12);
        check_vols("off99", 16'h4C50, 16'h3730, 16'h4340, 16'h4840);

        // Retrigger sounding note, then velocity-0 note-on releases it
        send(1'b1, 7'd67, 8'h7F);
        check_vols("retrig67", 16'h4C50, 16'h3730, 16'h437F, 16'h4840);
        check("retrig67.steal", 32'(steal), 32'd0);
        send(1'b1, 7'd67, 8'h00);
        check_vols("vel0_67", 16'h4C50, 16'h3730, 16'h4300, 16'h4840);
        check("vel0_67.active", 32'(voice_active), 32'hB);

        // Retrigger moved voice 2 to rank 0, so voice 3 is now the oldest
        send(1'b1, 7'd80, 8'h11);
        check_vols("on80", 16'h4C50, 16'h3730, 16'h5011, 16'h4840);
        send(1'b1, 7'd81, 8'h22);
        check_vols("steal81", 16'h4C50, 16'h3730, 16'h5011, 16'h5122);
        check("steal81.pulse", 32'(steal), 32'd1);

        // all_off and ev_valid together: all_off wins, event taken next cycle
        @(negedge clk);
        all_off  = 1'b1;
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = 7'h30;
        ev_vel   = 8'h10;
        #1;
        check("alloff.ready_low", 32'(ev_ready), 32'd0);
        @(posedge clk);
        #1;
        check_vols("alloff", 16'h4C00, 16'h3700, 16'h5000, 16'h5100);
        check("alloff.active", 32'(voice_active), 32'h0);
        @(negedge clk);
        all_off = 1'b0;
        #1;
        check("alloff.ready_back", 32'(ev_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
        check("alloff.busy", 32'(ev_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_vols("alloff_ev", 16'h3010, 16'h3700, 16'h5000, 16'h5100);
        check("alloff_ev.active", 32'(voice_active), 32'h1);
        check("alloff_ev.steal", 32'(steal), 32'd0);

        // Reset while the event sits in MATCH: nothing gets written
        @(negedge clk);
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = 7'h45;
        ev_vel   = 8'h55;
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_vols("midreset", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check("midreset.active", 32'(voice_active), 32'h0);
        check("midreset.steal", 32'(steal), 32'd0);
        check("midreset.ready", 32'(ev_ready), 32'd1);

        // Five notes after reset: fill in order, fifth steals the oldest
        send(1'b1, 7'd10, 8'h01);
        send(1'b1, 7'd20, 8'h01);
        send(1'b1, 7'd30, 8'h01);
        send(1'b1, 7'd40, 8'h01);
        check_vols("refill", 16'h0A01, 16'h1401, 16'h1E01, 16'h2801);
        send(1'b1, 7'd50, 8'h02);
        check_vols("refill_steal", 16'h3202, 16'h1401, 16'h1E01, 16'h2801);
        check("refill_steal.pulse", 32'(steal), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
